// File: rtl/mul_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Every block that works on the arbiter state or the request owner uses these types.
package mul_pkg;
  localparam int MUL_W  = 16;
  localparam int MUL_PW = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } mul_arb_state_t;

  typedef logic mul_owner_t;
endpackage

// File: rtl/mul.sv
// Combinational unsigned multiplier, full 2*W-bit product.
module mul import mul_pkg::*; #(
  parameter int W = MUL_W
) (
  input  logic [W-1:0]   inp1,
  input  logic [W-1:0]   inp2,
  output logic [2*W-1:0] mulo
);
  assign mulo = {{W{1'b0}}, inp1} * {{W{1'b0}}, inp2};
endmodule

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin grant. The caller holds the last_grant pointer;
// when both requesters are valid, the one that did not win last time gets the grant.
module rr_arb2 import mul_pkg::*; (
  input  logic       valid0,
  input  logic       valid1,
  input  mul_owner_t last_grant,
  output logic       grant_valid,
  output mul_owner_t grant
);
  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) grant = ~last_grant;
    else                  grant = valid1;
  end
endmodule

// File: rtl/mul_arbiter.sv
// Shares one combinational multiplier between two requesters.
// Requests are granted round-robin; the FSM walks IDLE -> EXEC -> RESP.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
// A requester holds valid and its payload stable until ready; ready never depends on rsp_ready.
module mul_arbiter import mul_pkg::*; #(
  parameter int W    = MUL_W,
  parameter int CNTW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [W-1:0]   req0_a,
  input  logic [W-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [W-1:0]   req1_a,
  input  logic [W-1:0]   req1_b,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [2*W-1:0] rsp_prod,
  output logic           rsp_ovf,
  output logic           busy,
  output logic [CNTW-1:0] ovf_cnt
);
  mul_arb_state_t state, next_state;
  mul_owner_t     owner, last_grant, grant;
  logic           grant_valid, rsp_take;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] product;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Multiplier sees only the registered operands, so requester ports may change after accept.
  mul #(.W(W)) u_mul (
    .inp1 (op_a),
    .inp2 (op_b),
    .mulo (product)
  );

  assign rsp_take = (owner == 1'b0) ? rsp0_ready : rsp1_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    next_state = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          next_state = EXEC;
          req0_ready = (grant == 1'b0);
          req1_ready = (grant == 1'b1);
        end
      end
      EXEC: next_state = RESP;
      RESP: begin
        rsp0_valid = (owner == 1'b0);
        rsp1_valid = (owner == 1'b1);
        if (rsp_take) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      rsp_prod   <= '0;
      rsp_ovf    <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && grant_valid) begin
        owner      <= grant;
        last_grant <= grant;
        op_a       <= grant ? req1_a : req0_a;
        op_b       <= grant ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        rsp_prod <= product;
        rsp_ovf  <= |product[2*W-1:W];
      end
      // Saturating count of overflowed products, bumped only when the owner takes one.
      if (state == RESP && rsp_take && rsp_ovf && (ovf_cnt != {CNTW{1'b1}}))
        ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: a transaction-level reference model checked every cycle,
// a product scoreboard, and hand-computed literal expectations.
module tb_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 0, req1_valid = 0;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 0, rsp1_ready = 0;
  logic [31:0] rsp_prod;
  logic        rsp_ovf, busy;
  logic [7:0]  ovf_cnt;

  int tests = 0;
  int fails = 0;

  mul_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_prod(rsp_prod), .rsp_ovf(rsp_ovf), .busy(busy), .ovf_cnt(ovf_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one outstanding job; response visible two edges after accept
  logic        started = 0;
  logic        m_idle = 1, m_last = 1, m_owner = 0;
  int          m_wait = 0;
  logic [31:0] m_prod = 0, m_show_prod = 0;
  logic        m_show_ovf = 0;
  int          m_cnt = 0;
  logic [31:0] exp_q[$];
  logic        grant_q[$];
  logic        log_grants = 0;

  function automatic logic pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started = 1; m_idle = 1; m_last = 1; m_wait = 0;
      m_show_prod = 0; m_show_ovf = 0; m_cnt = 0;
      exp_q.delete();
    end else if (m_idle) begin
      if (req0_valid || req1_valid) begin
        m_owner = pick(req0_valid, req1_valid, m_last);
        m_last  = m_owner;
        m_prod  = m_owner ? 32'(req1_a) * 32'(req1_b) : 32'(req0_a) * 32'(req0_b);
        exp_q.push_back(m_prod);
        m_idle = 0; m_wait = 1;
      end
    end else if (m_wait > 0) begin
      m_show_prod = m_prod;
      m_show_ovf  = (m_prod >= 32'd65536);
      m_wait = 0;
    end else if (m_owner ? rsp1_ready : rsp0_ready) begin
      m_idle = 1;
      if (m_show_ovf && m_cnt < 255) m_cnt++;
    end
  end

  // compare process
  always @(negedge clk) begin
    logic any_v, g, e_r0, e_r1, e_s0, e_s1;
    if (started) begin
      any_v = req0_valid | req1_valid;
      g     = pick(req0_valid, req1_valid, m_last);
      e_r0  = m_idle && any_v && !g;
      e_r1  = m_idle && any_v && g;
      e_s0  = !m_idle && m_wait == 0 && !m_owner;
      e_s1  = !m_idle && m_wait == 0 && m_owner;
      check("req0_ready", 32'(req0_ready), 32'(e_r0));
      check("req1_ready", 32'(req1_ready), 32'(e_r1));
      check("rsp0_valid", 32'(rsp0_valid), 32'(e_s0));
      check("rsp1_valid", 32'(rsp1_valid), 32'(e_s1));
      check("busy", 32'(busy), 32'(!m_idle));
      check("rsp_prod", rsp_prod, m_show_prod);
      check("rsp_ovf", 32'(rsp_ovf), 32'(m_show_ovf));
      check("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
      if (log_grants && req0_ready) grant_q.push_back(1'b0);
      if (log_grants && req1_ready) grant_q.push_back(1'b1);
      if ((e_s0 && rsp0_ready) || (e_s1 && rsp1_ready)) begin
        if (exp_q.size() == 0) check("sb_empty", 32'(exp_q.size()), 32'd1);
        else check("sb_prod", rsp_prod, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic txn(input int idx, input logic [15:0] a, input logic [15:0] b,
                     input logic [31:0] lit);
    if (idx == 0) begin req0_valid = 1; req0_a = a; req0_b = b; end
    else          begin req1_valid = 1; req1_a = a; req1_b = b; end
    tick();
    req0_valid = 0; req1_valid = 0;
    tick();
    check("lit_prod", rsp_prod, lit);
    check("lit_rsp_valid", 32'(idx == 0 ? rsp0_valid : rsp1_valid), 32'd1);
    if (idx == 0) rsp0_ready = 1; else rsp1_ready = 1;
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
  endtask

  initial begin
    do_reset();
    check("rst_prod", rsp_prod, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(ovf_cnt), 32'd0);

    // single request from req0
    txn(0, 16'd3, 16'd5, 32'd15);
    tick();

    // both valid and held: grants must alternate starting with req0
    do_reset();
    req0_a = 16'd3; req0_b = 16'd4; req1_a = 16'd5; req1_b = 16'd6;
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1; log_grants = 1;
    repeat (12) tick();
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0; log_grants = 0;
    tick();
    check("grant_count", 32'(grant_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check("grant_order", 32'(grant_q[i]), 32'(i % 2));

    // arithmetic boundaries and overflow count
    do_reset();
    txn(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    check("cnt_after_ffff", 32'(ovf_cnt), 32'd1);
    txn(1, 16'h0100, 16'h0100, 32'h00010000);
    check("cnt_after_65536", 32'(ovf_cnt), 32'd2);
    txn(1, 16'h00FF, 16'h0101, 32'h0000FFFF);
    check("cnt_after_ffff_fit", 32'(ovf_cnt), 32'd2);
    txn(0, 16'h0000, 16'h1234, 32'h0);

    // owner stalls the response while the other requester waits
    req0_valid = 1; req0_a = 16'd11; req0_b = 16'd13;
    tick();
    req0_valid = 0;
    req1_valid = 1; req1_a = 16'd20; req1_b = 16'd30;
    tick();
    for (int i = 0; i < 10; i++) begin
      rsp1_ready = i[0];
      tick();
      check("hold_prod", rsp_prod, 32'd143);
      check("hold_req1_ready", 32'(req1_ready), 32'd0);
    end
    rsp1_ready = 0; rsp0_ready = 1;
    tick();
    rsp0_ready = 0;
    tick();
    req1_valid = 0;
    tick();
    check("lit_req1_after_hold", rsp_prod, 32'd600);
    rsp1_ready = 1;
    tick();
    rsp1_ready = 0;

    // operand port change after the handshake has no effect
    req0_valid = 1; req0_a = 16'd7; req0_b = 16'd2;
    tick();
    req0_valid = 0; req0_a = 16'd9;
    tick();
    check("lit_operand_reg", rsp_prod, 32'd14);
    rsp0_ready = 1;
    tick();
    rsp0_ready = 0;

    // reset during EXEC
    req0_valid = 1; req0_a = 16'd3; req0_b = 16'd3;
    tick();
    req0_valid = 0; rst = 1;
    tick();
    rst = 0;
    check("rst_exec_busy", 32'(busy), 32'd0);
    check("rst_exec_prod", rsp_prod, 32'd0);
    tick();
    check("rst_exec_norsp", 32'(rsp0_valid), 32'd0);

    // reset during RESP
    req1_valid = 1; req1_a = 16'hFFFF; req1_b = 16'd2;
    tick();
    req1_valid = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    check("rst_resp_valid", 32'(rsp1_valid), 32'd0);
    check("rst_resp_prod", rsp_prod, 32'd0);
    check("rst_resp_ovf", 32'(rsp_ovf), 32'd0);

    txn(0, 16'd2, 16'd3, 32'd6);
    check("cnt_after_normal", 32'(ovf_cnt), 32'd0);

    // saturation of the overflow counter
    for (int i = 0; i < 256; i++) txn(0, 16'hFFFF, 16'd2, 32'h0001FFFE);
    check("cnt_saturated", 32'(ovf_cnt), 32'd255);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
Shares one 16x16 combinational multiplier between two requesters: req0 (ALU execute stage) and req1 (address/index unit).
- Arbitrates round-robin.
- Registers operands, sequences one multiply per grant and holds the registered 32-bit product until the owner accepts it.
- Flags results that do not fit in 16 bits (product >= 65536) and counts them, replacing the simulation-only overflow message with a synthesizable flag.

Parameters:
W, 16, operand width; product is 2*W bits
CNTW, 8, width of saturating overflow counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has operands
req0_ready  out  1  requester 0 operands accepted this cycle
req0_a  in  W  requester 0 multiplicand
req0_b  in  W  requester 0 multiplier
req1_valid  in  1  requester 1 has operands
req1_ready  out  1  requester 1 operands accepted this cycle
req1_a  in  W  requester 1 multiplicand
req1_b  in  W  requester 1 multiplier
rsp0_valid  out  1  product for requester 0 available
rsp0_ready  in  1  requester 0 takes product
rsp1_valid  out  1  product for requester 1 available
rsp1_ready  in  1  requester 1 takes product
rsp_prod  out  2*W  registered product (shared bus, qualified by rspN_valid)
rsp_ovf  out  1  product[2W-1:W] != 0
busy  out  1  state != IDLE
ovf_cnt  out  CNTW  saturating count of overflowed products delivered

Behaviour:
- One clock (clk); reset synchronous, active-high (rst). All state updates on rising clk.
- Reset values:
  - state=IDLE, last_grant=1 (so req0 wins first tie).
  - rsp_prod=0, rsp_ovf=0, ovf_cnt=0.
  - all ready/valid outputs 0, busy=0.
- State machine IDLE -> EXEC -> RESP -> IDLE.
  - IDLE:
    - grant = req0 if only req0_valid; req1 if only req1_valid.
    - If both are valid, grant goes to the requester != last_grant.
    - reqN_ready=1 combinationally for the granted N only.
    - On the handshake edge: latch a, b and owner; last_grant<=owner; go to EXEC.
    - No valid: stay in IDLE.
  - EXEC (1 cycle):
    - Multiplier is fed from the operand registers (never from the req ports).
    - Latch rsp_prod = op_a*op_b (unsigned, full 2W bits, no truncation).
    - Latch rsp_ovf = |prod[2W-1:W].
    - Go to RESP.
  - RESP:
    - rsp<owner>_valid=1; the other rsp valid stays 0.
    - rsp_prod and rsp_ovf are held stable.
    - On the edge where rsp<owner>_ready=1: go to IDLE, and ovf_cnt increments if rsp_ovf (saturates at 2^CNTW-1).
    - Ready from the non-owner is ignored.
- Latency: request handshake at edge N -> rspN_valid high from edge N+2. Minimum spacing between accepts is 3 cycles (no overlap of RESP with a new accept).
- reqN_ready is 0 in EXEC and RESP. Requesters must hold valid and operands until ready. The operand registers make later port changes harmless.
- Arithmetic boundary cases:
  - 0*x gives 0, ovf=0.
  - 0xFFFF*0xFFFF gives 0xFFFE0001, ovf=1.
  - 0x0100*0x0100 gives 0x00010000, ovf=1 (exactly 65536).
  - 0x00FF*0x0101 gives 0xFFFF, ovf=0.
- Starvation: with both valid continuously, grants alternate 0,1,0,1.
- Reset mid-operation (EXEC or RESP): transaction is dropped, no response is issued, all outputs return to reset values the next cycle, ovf_cnt=0.
- rsp_prod keeps its last value in IDLE; it is meaningful only while rspN_valid is high.

Decomposition:
- Shared package mul_pkg:
  - constants MUL_W=16, MUL_PW=32.
  - enum mul_arb_state_t {IDLE, EXEC, RESP}.
  - typedef mul_owner_t (1 bit).
- Sub-modules:
  - Instantiates the existing combinational multiplier mul (inp1=op_a, inp2=op_b, mulo=product).
  - One natural sub-module: rr_arb2, a 2-way round-robin grant from valids and last_grant. It is combinational, with the pointer held in the parent.

Test Plan:
- Reset, then req0 a=3 b=5 alone -> req0_ready same cycle; rsp0_valid 2 edges later with rsp_prod=15, rsp_ovf=0; rsp1_valid stays 0.
- req0 and req1 valid together, both held for 4 transactions -> grant order 0,1,0,1; each product routed only to its owner's rsp valid.
- req1 a=0xFFFF b=0xFFFF -> rsp_prod=0xFFFE0001, rsp_ovf=1. After accept, ovf_cnt=1. Then 0x0100*0x0100 -> 0x00010000, ovf=1, ovf_cnt=2. Then 0x00FF*0x0101 -> 0x0000FFFF, ovf=0, ovf_cnt=2.
- Owner holds rsp_ready=0 for 10 cycles while the other requester stays valid -> rsp_prod stable, busy=1, no req ready. Non-owner rsp_ready pulses are ignored.
- Change req0_a from 7 to 9 right after the handshake (b=2) -> product is 14.
- Assert rst in EXEC, then separately in RESP -> next cycle all outputs zero, state IDLE. A subsequent request completes normally. 256 overflow results then give ovf_cnt=255 (saturated).
